load_store_unit: RTL



---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_lane_align.sv | 63 ++++++
 rtl/load_store_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_pkg : shared encodings, FSM states and request error check for the LSU
// Rev 1.0
// ----------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  // A request is rejected when its size is reserved or the lane breaks natural alignment.
  function automatic logic lsu_req_err(input logic [1:0] size, input logic [1:0] lane);
    logic err;
    case (size)
      SIZE_BYTE: err = 1'b0;
      SIZE_HALF: err = lane[0];
      SIZE_WORD: err = |lane;
      default:   err = 1'b1;
    endcase
    return err;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_lane_align : load lane extract/extend and sub-word store merge
// Rev 1.0
// ----------------------------------------------------------------------------
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_sign,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_lane)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_load_data = i_word;
    case (i_size)
      SIZE_BYTE: o_load_data = {{24{i_sign & w_byte[7]}}, w_byte};
      SIZE_HALF: o_load_data = {{16{i_sign & w_half[15]}}, w_half};
      default:   o_load_data = i_word;
    endcase
  end

  // Only the addressed lane(s) change; the rest of the fetched word passes through.
  always_comb begin
    o_store_data = i_word;
    case (i_size)
      SIZE_BYTE: begin
        case (i_lane)
          2'd0:    o_store_data[7:0]   = i_wdata[7:0];
          2'd1:    o_store_data[15:8]  = i_wdata[7:0];
          2'd2:    o_store_data[23:16] = i_wdata[7:0];
          default: o_store_data[31:24] = i_wdata[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (i_lane[1]) o_store_data[31:16] = i_wdata[15:0];
        else           o_store_data[15:0]  = i_wdata[15:0];
      end
      SIZE_WORD: o_store_data = i_wdata;
      default:   o_store_data = i_word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// load_store_unit : multi-cycle byte/half/word load-store front end with RMW
// Rev 1.0
// ----------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_WrEn,
  output logic [ADDR_W-1:0] mem_Addr,
  output logic [31:0]       mem_Data_in,
  input  logic [31:0]       mem_Data_out
);

  lsu_state_t        r_state;
  lsu_state_t        w_state_nxt;

  logic              r_we;
  logic [1:0]        r_size;
  logic              r_sign;
  logic [1:0]        r_lane;
  logic [ADDR_W-1:0] r_idx;
  logic [31:0]       r_wdata;
  logic [31:0]       r_word;
  logic              r_err;

  logic              w_accept;
  logic              w_req_err;
  logic [31:0]       w_load_data;
  logic [31:0]       w_store_data;
  logic              w_unused_addr;

  assign w_accept      = req_valid && req_ready;
  assign w_req_err     = lsu_req_err(req_size, req_addr[1:0]);
  // Upper address bits alias onto the memory depth.
  assign w_unused_addr = ^req_addr[31:ADDR_W+2];

  lsu_lane_align u_align (
    .i_word       (r_word),
    .i_lane       (r_lane),
    .i_size       (r_size),
    .i_sign       (r_sign),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_store_data (w_store_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_size  <= SIZE_BYTE;
      r_sign  <= 1'b0;
      r_lane  <= 2'd0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_word  <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_size  <= req_size;
        r_sign  <= req_sign;
        r_lane  <= req_addr[1:0];
        r_idx   <= req_addr[ADDR_W+1:2];
        r_wdata <= req_wdata;
        r_err   <= w_req_err;
      end
      if (r_state == ST_READ) r_word <= mem_Data_out;
    end
  end

  // Every output is gated by rst_n so the interface is quiet for the whole reset window.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    resp_rdata  = 32'd0;
    mem_WrEn    = 1'b0;
    mem_Addr    = '0;
    mem_Data_in = 32'd0;
    if (rst_n) begin
      case (r_state)
        ST_IDLE: begin
          req_ready = 1'b1;
          if (req_valid) begin
            if (w_req_err)                           w_state_nxt = ST_RESP;
            else if (req_we && req_size == SIZE_WORD) w_state_nxt = ST_WRITE;
            else                                      w_state_nxt = ST_READ;
          end
        end
        ST_READ: begin
          mem_Addr    = r_idx;
          w_state_nxt = r_we ? ST_WRITE : ST_RESP;
        end
        ST_WRITE: begin
          mem_WrEn    = 1'b1;
          mem_Addr    = r_idx;
          mem_Data_in = w_store_data;
          w_state_nxt = ST_RESP;
        end
        default: begin
          resp_valid  = 1'b1;
          resp_err    = r_err;
          resp_rdata  = (r_we || r_err) ? 32'd0 : w_load_data;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
